input_module: RTL and testbench
===============================

Name: input_module

Overview:
- Input port stage of a mesh NoC router.
- Pops single-flit packets from an upstream first-word-fall-through (FWFT) FIFO into an internal DEPTH-entry buffer.
- Computes each flit's output direction from its header at write time (XY or YX dimension-order routing) and stores it with the flit.
- Presents the head flit and its direction to the switch/VC allocator, which consumes it with read_en.

Parameters:
- MSB_SLOT, 5, log2 of flit width.
- DSIZE, 1<<MSB_SLOT (32), flit width in bits.
- RRSIZE, 1<<(MSB_SLOT-2) (8), width of each destination coordinate field.
- ADDRSIZE, 5, internal buffer address width.
- DEPTH, 1<<ADDRSIZE (32), internal buffer entries.
- PORT, 3'b000, direction code of the port this instance serves.
- ROUTER_X, 1, this router's X coordinate (RRSIZE bits).
- ROUTER_Y, 1, this router's Y coordinate (RRSIZE bits).
- algorithm, 0, routing algorithm: 0 = XY, 1 = YX, any other value behaves as XY.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DSIZE  head word of the upstream FIFO; valid whenever input_empty=0.
- input_empty  in  1  upstream FIFO empty flag.
- input_read  out  1  pop strobe to the upstream FIFO; data_in is captured on the same edge.
- read_en  in  1  downstream pop of the head flit.
- data_out  out  DSIZE  head flit of the internal buffer.
- vc_select  out  3  route of the head flit.

Behaviour:
- Shared constants for direction codes: N=000, S=001, E=010, W=011, L=100, INVALID=111.
- Header fields:
  - dest_x = data_in[DSIZE-1 -: RRSIZE].
  - dest_y = data_in[DSIZE-RRSIZE-1 -: RRSIZE].
  - Remaining bits are payload, passed through unchanged.
  - Coordinate comparisons are unsigned.
- XY routing (algorithm=0):
  - dest_x > ROUTER_X -> E.
  - dest_x < ROUTER_X -> W.
  - Otherwise: dest_y > ROUTER_Y -> S; dest_y < ROUTER_Y -> N; else L.
- YX routing (algorithm=1): compare Y first, then X, using the same code mapping.
- U-turn rule: if the computed direction equals PORT and PORT != L, the stored route is INVALID. The flit is still buffered and delivered; downstream drops it.
- input_read = !reset && !input_empty && !full. This is combinational.
- Write: when input_read=1, at the rising edge store {route, data_in} at wr_ptr and increment wr_ptr.
- Read: when read_en=1 and the buffer is not empty, at the rising edge increment rd_ptr.
- read_en while empty is ignored: no pointer change.
- Pointers are ADDRSIZE+1 bits, with wrap-around modulo 2*DEPTH.
  - empty when wr_ptr == rd_ptr.
  - full when the MSBs differ and the low bits are equal.
- A simultaneous read and write in the same cycle are both performed; occupancy is unchanged.
- When full, input_read=0 even if read_en=1 in the same cycle. There is no write-through.
- Outputs:
  - data_out and vc_select are combinational from the head entry.
  - When empty: data_out=0 and vc_select=INVALID.
  - A flit written at edge k is visible at the outputs after edge k, provided the buffer was empty; latency is 1 cycle.
- Reset (synchronous): wr_ptr=rd_ptr=0. Resulting outputs: input_read=0, data_out=0, vc_select=INVALID.
- Reset asserted mid-operation discards all buffered flits at that edge.
- Storage contents need not be cleared on reset.

Decomposition:
- Package noc_pkg holds the direction codes (N, S, E, W, L, INVALID) and the header field offset helpers.
- One natural sub-module: route_compute. It is combinational: dest_x and dest_y plus parameters in, 3-bit direction out.
- The buffer is inline in input_module.

Test Plan:
- Reset held 2 cycles with input_empty=1 -> input_read=0, vc_select=111, data_out=0.
- Defaults (PORT=N, router at (1,1)). For each header, input_empty=0 for one cycle, then read_en=1 for one cycle:
  - 0x01010001 -> vc_select=L(100), data_out=0x01010001.
  - 0x01020001 -> S(001).
  - 0x00010001 -> W(011).
  - 0x02010001 -> E(010).
- 0x01000001 arriving on PORT=N (routes N) -> vc_select=INVALID(111); flit still delivered on data_out.
- algorithm=1, header 0x02020001 -> vc_select=S; with algorithm=0 the same header gives E.
- input_empty=0 and read_en=0 for 33 cycles -> input_read drops after 32 writes. Then read_en=1 for 32 cycles -> flits come out in order, and vc_select=111 after the last pop.
- Simultaneous read and write with 5 entries buffered -> occupancy stays 5. reset=1 mid-stream -> buffer reads empty the cycle after.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output direction codes and header field locators.
// Imported by the input port stage and its routing helper.
package noc_pkg;

  // Output direction codes used by the router.
  typedef enum logic [2:0] {
    DIR_N       = 3'b000,
    DIR_S       = 3'b001,
    DIR_E       = 3'b010,
    DIR_W       = 3'b011,
    DIR_L       = 3'b100,
    DIR_INVALID = 3'b111
  } dir_e;

  localparam int unsigned DIR_W_BITS = 3;

  // Bit index of the top of the destination X field (it is the flit's MSB field).
  function automatic int unsigned dest_x_msb(input int unsigned dsize);
    return dsize - 1;
  endfunction

  // Bit index of the top of the destination Y field, directly below X.
  function automatic int unsigned dest_y_msb(input int unsigned dsize,
                                             input int unsigned rrsize);
    return dsize - rrsize - 1;
  endfunction

endpackage

// File: rtl/input_module_route_compute.sv
// Dimension-order route computation for one flit header.
// Ports:
//   dest_x, dest_y : destination coordinates taken from the header
//   route_c        : combinational output direction (INVALID on a U-turn)
module route_compute
  import noc_pkg::*;
#(
  parameter int unsigned       RRSIZE    = 8,
  parameter logic [RRSIZE-1:0] ROUTER_X  = RRSIZE'(1),
  parameter logic [RRSIZE-1:0] ROUTER_Y  = RRSIZE'(1),
  parameter int unsigned       ALGORITHM = 0,
  parameter logic [2:0]        PORT      = DIR_N
) (
  input  logic [RRSIZE-1:0] dest_x,
  input  logic [RRSIZE-1:0] dest_y,
  output dir_e              route_c
);

  // Any algorithm value other than 1 falls back to XY ordering.
  localparam bit USE_YX = (ALGORITHM == 1);

  dir_e x_dir;
  dir_e y_dir;
  dir_e raw_dir;

  // Per-dimension decisions; unsigned compares against this router's position.
  always_comb begin
    x_dir = DIR_L;
    y_dir = DIR_L;
    if (dest_x > ROUTER_X) begin
      x_dir = DIR_E;
    end else if (dest_x < ROUTER_X) begin
      x_dir = DIR_W;
    end
    if (dest_y > ROUTER_Y) begin
      y_dir = DIR_S;
    end else if (dest_y < ROUTER_Y) begin
      y_dir = DIR_N;
    end
  end

  // Resolve the first dimension, fall through to the second once it matches.
  always_comb begin
    raw_dir = DIR_L;
    if (USE_YX) begin
      raw_dir = (y_dir != DIR_L) ? y_dir : x_dir;
    end else begin
      raw_dir = (x_dir != DIR_L) ? x_dir : y_dir;
    end
  end

  // A flit may not leave through the port it came in on, except local.
  always_comb begin
    route_c = raw_dir;
    if ((3'(raw_dir) == PORT) && (PORT != 3'(DIR_L))) begin
      route_c = DIR_INVALID;
    end
  end

endmodule

// File: rtl/input_module.sv
// Input port stage of a mesh NoC router. Pops flits from an upstream FWFT
// FIFO, tags each with its routed direction at write time and buffers
// {route, flit} until the switch allocator consumes the head.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   data_in      : upstream FIFO head word (valid while input_empty=0)
//   input_empty  : upstream FIFO empty flag
//   input_read   : combinational pop strobe to the upstream FIFO
//   read_en      : downstream pop of the head flit
//   data_out     : head flit (0 when empty)
//   vc_select    : head flit route (INVALID when empty)
module input_module
  import noc_pkg::*;
#(
  parameter int unsigned       MSB_SLOT  = 5,
  parameter int unsigned       DSIZE     = 1 << MSB_SLOT,
  parameter int unsigned       RRSIZE    = 1 << (MSB_SLOT - 2),
  parameter int unsigned       ADDRSIZE  = 5,
  parameter int unsigned       DEPTH     = 1 << ADDRSIZE,
  parameter logic [2:0]        PORT      = DIR_N,
  parameter logic [RRSIZE-1:0] ROUTER_X  = RRSIZE'(1),
  parameter logic [RRSIZE-1:0] ROUTER_Y  = RRSIZE'(1),
  parameter int unsigned       algorithm = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] data_in,
  input  logic             input_empty,
  output logic             input_read,
  input  logic             read_en,
  output logic [DSIZE-1:0] data_out,
  output logic [2:0]       vc_select
);

  localparam int unsigned ENTRY_W = DSIZE + DIR_W_BITS;
  localparam int unsigned X_MSB   = dest_x_msb(DSIZE);
  localparam int unsigned Y_MSB   = dest_y_msb(DSIZE, RRSIZE);
  localparam logic [ADDRSIZE:0] PTR_ONE = (ADDRSIZE + 1)'(1);

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ADDRSIZE:0]   wr_ptr;
  logic [ADDRSIZE:0]   rd_ptr;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE-1:0] rd_addr;
  logic                empty;
  logic                full;
  logic                rd_fire;
  logic [ENTRY_W-1:0]  head;
  logic [RRSIZE-1:0]   dest_x;
  logic [RRSIZE-1:0]   dest_y;
  dir_e                route_c;

  // Header fields of the incoming word.
  assign dest_x = data_in[X_MSB -: RRSIZE];
  assign dest_y = data_in[Y_MSB -: RRSIZE];

  route_compute #(
    .RRSIZE    (RRSIZE),
    .ROUTER_X  (ROUTER_X),
    .ROUTER_Y  (ROUTER_Y),
    .ALGORITHM (algorithm),
    .PORT      (PORT)
  ) u_route (
    .dest_x  (dest_x),
    .dest_y  (dest_y),
    .route_c (route_c)
  );

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign wr_addr = wr_ptr[ADDRSIZE-1:0];
  assign rd_addr = rd_ptr[ADDRSIZE-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDRSIZE] != rd_ptr[ADDRSIZE]) &&
                   (wr_addr == rd_addr);

  // No write-through: a full buffer refuses data even if the head pops now.
  assign input_read = !reset && !input_empty && !full;
  assign rd_fire    = read_en && !empty;

  // Pointer update; reset drops all buffered flits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (input_read) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are left as-is on reset.
  always_ff @(posedge clk) begin
    if (input_read) begin
      mem[wr_addr] <= {3'(route_c), data_in};
    end
  end

  // Head presentation, blanked when nothing is buffered.
  assign head = mem[rd_addr];

  always_comb begin
    data_out  = '0;
    vc_select = 3'(DIR_INVALID);
    if (!empty) begin
      data_out  = head[DSIZE-1:0];
      vc_select = head[ENTRY_W-1 -: DIR_W_BITS];
    end
  end

endmodule

// File: tb/tb_input_module.sv
module tb_input_module;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        input_empty;
  logic        read_en;
  logic        ird_xy, ird_yx;
  logic [31:0] dout_xy, dout_yx;
  logic [2:0]  vc_xy, vc_yx;

  int n_chk = 0;
  int n_bad = 0;
  int ird_seen = 0;

  logic [31:0] q[$];

  input_module dut (
    .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
    .input_read(ird_xy), .read_en(read_en), .data_out(dout_xy), .vc_select(vc_xy)
  );

  input_module #(.algorithm(1)) dut_yx (
    .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
    .input_read(ird_yx), .read_en(read_en), .data_out(dout_yx), .vc_select(vc_yx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference route from coordinate differences; router at (1,1), port N.
  function automatic logic [2:0] ref_route(input logic [31:0] f, input int alg);
    int dx, dy;
    logic [2:0] xd, yd, r;
    dx = int'(f[31:24]) - 1;
    dy = int'(f[23:16]) - 1;
    xd = (dx > 0) ? 3'b010 : (dx < 0) ? 3'b011 : 3'b100;
    yd = (dy > 0) ? 3'b001 : (dy < 0) ? 3'b000 : 3'b100;
    if (alg == 1) r = (dy != 0) ? yd : xd;
    else          r = (dx != 0) ? xd : yd;
    if (r == 3'b000) r = 3'b111;
    return r;
  endfunction

  // One cycle: drive, check against the model, clock, update the model.
  task automatic step(input logic rst, input logic emp, input logic [31:0] din,
                      input logic ren);
    logic exp_ird;
    logic [31:0] hd;
    reset = rst; input_empty = emp; data_in = din; read_en = ren;
    #1;
    exp_ird = !rst && !emp && (q.size() < 32);
    chk("input_read", 64'(ird_xy), 64'(exp_ird));
    chk("input_read_yx", 64'(ird_yx), 64'(exp_ird));
    if (ird_xy === 1'b1) ird_seen++;
    if (q.size() == 0) begin
      chk("data_out_empty", 64'(dout_xy), 64'(0));
      chk("vc_empty", 64'(vc_xy), 64'(3'b111));
      chk("vc_yx_empty", 64'(vc_yx), 64'(3'b111));
    end else begin
      hd = q[0];
      chk("data_out", 64'(dout_xy), 64'(hd));
      chk("data_out_yx", 64'(dout_yx), 64'(hd));
      chk("vc_select", 64'(vc_xy), 64'(ref_route(hd, 0)));
      chk("vc_select_yx", 64'(vc_yx), 64'(ref_route(hd, 1)));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (ren && q.size() > 0) void'(q.pop_front());
      if (exp_ird) q.push_back(din);
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [2:0]  exp_xy;
    logic [2:0]  exp_yx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt;
    logic [31:0] h;
    logic ren_b, emp_b, rst_b;

    vecs[0] = '{32'h0101_0001, 3'b100, 3'b100};
    vecs[1] = '{32'h0102_0001, 3'b001, 3'b001};
    vecs[2] = '{32'h0001_0001, 3'b011, 3'b011};
    vecs[3] = '{32'h0201_0001, 3'b010, 3'b010};
    vecs[4] = '{32'h0100_0001, 3'b111, 3'b111};
    vecs[5] = '{32'h0202_0001, 3'b010, 3'b001};

    reset = 1'b1; input_empty = 1'b1; data_in = '0; read_en = 1'b0;
    @(posedge clk); #1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("post_reset_vc", 64'(vc_xy), 64'(3'b111));
    chk("post_reset_dout", 64'(dout_xy), 64'(0));

    // Table-driven routing vectors: write one flit, check head, pop it.
    foreach (vecs[i]) begin
      step(0, 0, vecs[i].hdr, 0);
      chk($sformatf("vec%0d_data", i), 64'(dout_xy), 64'(vecs[i].hdr));
      chk($sformatf("vec%0d_xy", i), 64'(vc_xy), 64'(vecs[i].exp_xy));
      chk($sformatf("vec%0d_yx", i), 64'(vc_yx), 64'(vecs[i].exp_yx));
      step(0, 1, 0, 1);
      chk($sformatf("vec%0d_drained", i), 64'(vc_xy), 64'(3'b111));
    end

    // Fill to full: only 32 of 33 offered words may be taken.
    ird_seen = 0;
    for (int i = 0; i < 33; i++) step(0, 0, {8'(i % 4), 8'(i % 3), 16'(i)}, 0);
    chk("full_write_count", 64'(ird_seen), 64'(32));
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("order%0d", i), 64'(dout_xy[15:0]), 64'(i));
      step(0, 1, 0, 1);
    end
    chk("after_drain_vc", 64'(vc_xy), 64'(3'b111));

    // Simultaneous read and write keeps occupancy at 5.
    for (int i = 0; i < 5; i++) step(0, 0, {8'd2, 8'd1, 16'(i)}, 0);
    for (int i = 0; i < 4; i++) step(0, 0, {8'd1, 8'd2, 16'(100 + i)}, 1);
    cnt = 0;
    while (!(vc_xy === 3'b111 && dout_xy === 32'h0) && cnt < 40) begin
      step(0, 1, 0, 1);
      cnt++;
    end
    chk("simul_occupancy", 64'(cnt), 64'(5));

    // Reset mid-stream discards buffered flits.
    for (int i = 0; i < 3; i++) step(0, 0, {8'd0, 8'd1, 16'(i)}, 0);
    step(1, 0, 32'h0201_0005, 1);
    chk("midreset_dout", 64'(dout_xy), 64'(0));
    chk("midreset_vc", 64'(vc_xy), 64'(3'b111));
    step(0, 1, 0, 0);

    // Randomized traffic against the queue model, with phases biasing full/empty.
    for (int i = 0; i < 3000; i++) begin
      h = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 16'($urandom)};
      rst_b = ($urandom_range(0, 299) == 0);
      emp_b = ($urandom_range(0, 3) == 0);
      if ((i / 300) % 2 == 0) ren_b = ($urandom_range(0, 4) == 0);
      else                    ren_b = ($urandom_range(0, 4) != 0);
      step(rst_b, emp_b, h, ren_b);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
